ahb_imem_responder: RTL and testbench

- AHB3-Lite slave that answers the RV12 core's instruction-fetch port from a small loadable program buffer.
- It is the responder end of the fetch interface. The bench or formal harness preloads a short program, then the core fetches and retires it, so retired instructions can be checked.
- Provides programmable wait states, ERROR responses and NOP fill past program end.
- Sits between the core's instruction AHB master port and the testbench top.

---
 rtl/ahb_imem_responder_if.sv | 25 ++
 rtl/ahb_imem_responder.sv | 175 +++++++++++++++++
 tb/tb_ahb_imem_responder.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_imem_responder_if.sv
// AHB3-Lite bus bundle between the core's instruction-fetch master and
// the program-buffer responder.
interface ahb_imem_responder_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic        HREADY;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HREADY,
        input  HRDATA, HREADYOUT, HRESP
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HREADY,
        output HRDATA, HREADYOUT, HRESP
    );
endinterface

// File: rtl/ahb_imem_responder.sv
// Instruction-fetch responder: serves 32-bit reads from a loadable program
// buffer with programmable wait states, a two-cycle ERROR response for
// illegal accesses and NOP fill past the loaded program length.
module ahb_imem_responder #(
    parameter logic [31:0] BASE_ADDR = 32'h200,
    parameter int          DEPTH     = 64,
    parameter logic [31:0] NOP_WORD  = 32'h0000_0013,
    parameter int          WAIT_W    = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    ahb_imem_responder_if.slave        ahb,
    input  logic                       load_we,
    input  logic [$clog2(DEPTH)-1:0]   load_idx,
    input  logic [31:0]                load_data,
    input  logic [$clog2(DEPTH):0]     prog_len,
    input  logic [WAIT_W-1:0]          cfg_wait,
    output logic [15:0]                fetch_count
);

    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_OKAY,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [31:0]        r_buf [DEPTH];
    logic [IDX_W-1:0]   r_idx;
    logic [WAIT_W-1:0]  r_wcnt;
    logic [31:0]        r_hrdata;
    logic [15:0]        r_fetch_cnt;

    logic               w_acc;
    logic               w_can_acc;
    logic               w_take;
    logic [31:0]        w_off;
    logic [31:0]        w_idx_full;
    logic [IDX_W-1:0]   w_idx;
    logic               w_legal;
    logic [IDX_W:0]     w_plen;
    logic [IDX_W-1:0]   w_rd_idx;
    logic [31:0]        w_rd_word;
    logic               w_load_wait;
    logic               w_unused_ok;

    // Address-phase decode: accept qualification, word index and legality.
    always_comb begin
        w_acc      = ahb.HSEL & ahb.HTRANS[1] & ahb.HREADY;
        w_can_acc  = (r_state == S_IDLE) | (r_state == S_OKAY) | (r_state == S_ERR2);
        w_take     = w_acc & w_can_acc;
        // Subtraction only meaningful when HADDR >= BASE_ADDR; the legality
        // term below rejects lower addresses so wrap-around never aliases.
        w_off      = ahb.HADDR - BASE_ADDR;
        w_idx_full = {2'b00, w_off[31:2]};
        w_idx      = w_off[IDX_W+1:2];
        w_legal    = !ahb.HWRITE
                   && (ahb.HSIZE == 3'b010)
                   && (ahb.HADDR[1:0] == 2'b00)
                   && (ahb.HADDR >= BASE_ADDR)
                   && (w_idx_full < 32'(DEPTH));
        // Lengths beyond the buffer behave as a full buffer.
        w_plen     = (prog_len > (IDX_W+1)'(DEPTH)) ? (IDX_W+1)'(DEPTH) : prog_len;
    end

    // Next-state logic and bus response decode.
    always_comb begin
        w_state_nxt   = r_state;
        w_load_wait   = 1'b0;
        w_rd_idx      = r_idx;
        ahb.HREADYOUT = 1'b1;
        ahb.HRESP     = 1'b0;
        case (r_state)
            S_IDLE, S_OKAY, S_ERR2: begin
                if (r_state == S_ERR2) begin
                    ahb.HRESP = 1'b1;
                end
                if (r_state != S_IDLE) begin
                    w_state_nxt = S_IDLE;
                end
                if (w_take) begin
                    if (!w_legal) begin
                        w_state_nxt = S_ERR1;
                    end else if (cfg_wait == '0) begin
                        w_state_nxt = S_OKAY;
                        w_rd_idx    = w_idx;
                    end else begin
                        w_state_nxt = S_WAIT;
                        w_load_wait = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                ahb.HREADYOUT = 1'b0;
                if (r_wcnt == WAIT_W'(1)) begin
                    w_state_nxt = S_OKAY;
                end
            end
            S_ERR1: begin
                ahb.HREADYOUT = 1'b0;
                ahb.HRESP     = 1'b1;
                w_state_nxt   = S_ERR2;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Buffer read for the word about to be presented; reads see the value
    // before any load_we landing on the same edge.
    always_comb begin
        w_rd_word = ({1'b0, w_rd_idx} < w_plen) ? r_buf[w_rd_idx] : NOP_WORD;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Transfer bookkeeping: captured index, wait counter, read data, fetch count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx       <= '0;
            r_wcnt      <= '0;
            r_hrdata    <= '0;
            r_fetch_cnt <= '0;
        end else begin
            if (w_take) begin
                r_idx <= w_idx;
            end
            if (w_load_wait) begin
                r_wcnt <= cfg_wait;
            end else if (r_state == S_WAIT) begin
                r_wcnt <= r_wcnt - WAIT_W'(1);
            end
            if (w_state_nxt == S_OKAY) begin
                r_hrdata <= w_rd_word;
            end
            if ((r_state == S_OKAY) && (r_fetch_cnt != 16'hFFFF)) begin
                r_fetch_cnt <= r_fetch_cnt + 16'd1;
            end
        end
    end

    // Program buffer: reset fills with NOPs, loads accepted in any state.
    // load_idx is IDX_W bits wide and DEPTH is a power of two, so every
    // representable index is in range.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_buf[i] <= NOP_WORD;
            end
        end else if (load_we) begin
            r_buf[load_idx] <= load_data;
        end
    end

    assign ahb.HRDATA  = r_hrdata;
    assign fetch_count = r_fetch_cnt;

    // Burst type and protection carry no meaning for this responder.
    assign w_unused_ok = ^{ahb.HBURST, ahb.HPROT, w_off[1:0]};

endmodule

// File: tb/tb_ahb_imem_responder.sv
// Directed bench for the instruction-fetch responder.
module tb_ahb_imem_responder;

    localparam int DEPTH = 64;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        load_we;
    logic [5:0]  load_idx;
    logic [31:0] load_data;
    logic [6:0]  prog_len;
    logic [3:0]  cfg_wait;
    logic [15:0] fetch_count;

    int n_total;
    int n_bad;
    int n_low;

    ahb_imem_responder_if bus ();

    ahb_imem_responder #(
        .BASE_ADDR (32'h200),
        .DEPTH     (DEPTH),
        .NOP_WORD  (NOP),
        .WAIT_W    (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ahb         (bus),
        .load_we     (load_we),
        .load_idx    (load_idx),
        .load_data   (load_data),
        .prog_len    (prog_len),
        .cfg_wait    (cfg_wait),
        .fetch_count (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic addr(input logic [31:0] a, input logic [1:0] tr, input logic wr, input logic [2:0] sz);
        bus.HSEL   = 1'b1;
        bus.HADDR  = a;
        bus.HTRANS = tr;
        bus.HWRITE = wr;
        bus.HSIZE  = sz;
    endtask

    task automatic idle();
        bus.HSEL   = 1'b0;
        bus.HTRANS = 2'b00;
        bus.HWRITE = 1'b0;
        bus.HSIZE  = 3'b010;
    endtask

    task automatic load_word(input logic [5:0] idx, input logic [31:0] d);
        load_we   = 1'b1;
        load_idx  = idx;
        load_data = d;
        cyc();
        load_we   = 1'b0;
    endtask

    // Illegal-access vectors: address, write, size.
    logic [31:0] bad_a  [5] = '{32'h300, 32'h1FC, 32'h200, 32'h200, 32'h202};
    logic        bad_w  [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [2:0]  bad_sz [5] = '{3'd2, 3'd2, 3'd2, 3'd1, 3'd2};

    initial begin
        n_total    = 0;
        n_bad      = 0;
        bus.HBURST = 3'b000;
        bus.HPROT  = 4'b0011;
        bus.HREADY = 1'b1;
        bus.HADDR  = 32'h0;
        idle();
        load_we    = 1'b0;
        load_idx   = '0;
        load_data  = '0;
        prog_len   = 7'd0;
        cfg_wait   = 4'd0;
        rst_n      = 1'b0;
        repeat (3) cyc();
        rst_n = 1'b1;
        cyc();

        // Reset state
        chk("rst_ready", 32'(bus.HREADYOUT), 32'd1);
        chk("rst_resp",  32'(bus.HRESP),     32'd0);
        chk("rst_rdata", bus.HRDATA,         32'h0);
        chk("rst_fc",    32'(fetch_count),   32'd0);

        // Load program and fetch back-to-back with zero wait
        load_word(6'd0, 32'h0050_0093);
        load_word(6'd1, 32'h00A0_0113);
        load_word(6'd2, 32'h0020_81B3);
        prog_len = 7'd3;
        addr(32'h200, 2'b10, 1'b0, 3'd2);
        cyc();
        chk("b2b0_data",  bus.HRDATA, 32'h0050_0093);
        chk("b2b0_ready", 32'(bus.HREADYOUT), 32'd1);
        addr(32'h204, 2'b11, 1'b0, 3'd2);
        cyc();
        chk("b2b1_data",  bus.HRDATA, 32'h00A0_0113);
        chk("b2b1_ready", 32'(bus.HREADYOUT), 32'd1);
        addr(32'h208, 2'b11, 1'b0, 3'd2);
        cyc();
        chk("b2b2_data",  bus.HRDATA, 32'h0020_81B3);
        chk("b2b2_resp",  32'(bus.HRESP), 32'd0);
        idle();
        cyc();
        chk("b2b_fc", 32'(fetch_count), 32'd3);

        // BUSY with select is not accepted
        addr(32'h200, 2'b01, 1'b0, 3'd2);
        cyc();
        idle();
        chk("busy_ready", 32'(bus.HREADYOUT), 32'd1);
        cyc();
        chk("busy_fc", 32'(fetch_count), 32'd3);

        // Three wait states; cfg_wait changed after accept must not matter
        cfg_wait = 4'd3;
        addr(32'h200, 2'b10, 1'b0, 3'd2);
        cyc();
        idle();
        cfg_wait = 4'd0;
        n_low = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.HREADYOUT) break;
            n_low++;
            cyc();
        end
        chk("wait_low_cycles", 32'(n_low), 32'd3);
        chk("wait_data", bus.HRDATA, 32'h0050_0093);
        chk("wait_resp", 32'(bus.HRESP), 32'd0);
        cyc();
        chk("wait_fc", 32'(fetch_count), 32'd4);

        // Past program end returns NOP
        addr(32'h20C, 2'b10, 1'b0, 3'd2);
        cyc();
        idle();
        chk("nop_data",  bus.HRDATA, NOP);
        chk("nop_resp",  32'(bus.HRESP), 32'd0);
        chk("nop_ready", 32'(bus.HREADYOUT), 32'd1);
        cyc();
        // Last in-range word
        addr(32'h2FC, 2'b10, 1'b0, 3'd2);
        cyc();
        idle();
        chk("last_data", bus.HRDATA, NOP);
        chk("last_resp", 32'(bus.HRESP), 32'd0);
        cyc();
        chk("nop_fc", 32'(fetch_count), 32'd6);

        // Illegal accesses: two-cycle ERROR each
        for (int k = 0; k < 5; k++) begin
            addr(bad_a[k], 2'b10, bad_w[k], bad_sz[k]);
            cyc();
            idle();
            chk($sformatf("err1_ready_%0d", k), 32'(bus.HREADYOUT), 32'd0);
            chk($sformatf("err1_resp_%0d", k),  32'(bus.HRESP),     32'd1);
            cyc();
            chk($sformatf("err2_ready_%0d", k), 32'(bus.HREADYOUT), 32'd1);
            chk($sformatf("err2_resp_%0d", k),  32'(bus.HRESP),     32'd1);
            cyc();
            chk($sformatf("err_idle_resp_%0d", k), 32'(bus.HRESP), 32'd0);
        end
        chk("err_fc", 32'(fetch_count), 32'd6);

        // Buffer unchanged by the write transfer; load collides with read
        addr(32'h200, 2'b10, 1'b0, 3'd2);
        load_we   = 1'b1;
        load_idx  = 6'd0;
        load_data = 32'hDEAD_BEEF;
        cyc();
        load_we = 1'b0;
        idle();
        chk("rdw_old", bus.HRDATA, 32'h0050_0093);
        cyc();
        addr(32'h200, 2'b10, 1'b0, 3'd2);
        cyc();
        idle();
        chk("rdw_new", bus.HRDATA, 32'hDEAD_BEEF);
        cyc();
        chk("rdw_fc", 32'(fetch_count), 32'd8);

        // Asynchronous reset in the middle of a waited transfer
        cfg_wait = 4'd5;
        addr(32'h204, 2'b10, 1'b0, 3'd2);
        cyc();
        idle();
        cyc();
        chk("mid_wait_ready", 32'(bus.HREADYOUT), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_ready", 32'(bus.HREADYOUT), 32'd1);
        chk("arst_resp",  32'(bus.HRESP),     32'd0);
        chk("arst_rdata", bus.HRDATA,         32'h0);
        chk("arst_fc",    32'(fetch_count),   32'd0);
        cyc();
        rst_n    = 1'b1;
        cfg_wait = 4'd0;
        cyc();
        chk("post_rst_idle", 32'(bus.HREADYOUT), 32'd1);
        addr(32'h200, 2'b10, 1'b0, 3'd2);
        cyc();
        chk("post_rst_w0", bus.HRDATA, NOP);
        addr(32'h204, 2'b11, 1'b0, 3'd2);
        cyc();
        idle();
        chk("post_rst_w1", bus.HRDATA, NOP);
        cyc();
        chk("post_rst_fc", 32'(fetch_count), 32'd2);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
